ip_hash_arbiter: RTL and testbench
==================================

# ip_hash_arbiter

Shares one `ip_hash_controller` instance between `NUM_REQ` requesters. Each requester issues insert or lookup operations through a valid/ready handshake. The arbiter grants one requester per cycle in round-robin order, enforces the controller's insert hazard gap, and registers the winning operation onto the controller inputs. It then tags every in-flight lookup so the controller's `found` result is routed back to the originating requester.

## Interface
- `NUM_REQ`, 4: number of requesters, ≥2.
- `IP_ADDR_W`, 32: IP address width.
- `LOOKUP_LAT`, 2: cycles from controller input to `found_valid_i`; must equal the controller's `PIPE_DEPTH`.
- `INSERT_GAP`, 2: grant-blocked cycles following an insert grant.
- `TAG_W`, `$clog2(NUM_REQ)`: derived localparam.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid_i`  in  `NUM_REQ`  per-requester request valid.
- `req_insert_i`  in  `NUM_REQ`  per-requester op: 1 = insert, 0 = lookup.
- `req_ip_addr_i`  in  `NUM_REQ*IP_ADDR_W`  packed addresses; requester i occupies `[i*IP_ADDR_W +: IP_ADDR_W]`.
- `req_ready_o`  out  `NUM_REQ`  one-hot grant (combinational); the request is accepted when valid & ready.
- `insert_val_o`  out  1  to controller `insert_val_i` (registered).
- `look_up_val_o`  out  1  to controller `look_up_val_i` (registered).
- `ip_addr_o`  out  `IP_ADDR_W`  to controller `ip_addr_i` (registered).
- `found_valid_i`  in  1  controller `ip_addr_found_if_o.valid`.
- `found_i`  in  1  controller `ip_addr_found_if_o.data`.
- `resp_valid_o`  out  `NUM_REQ`  one-hot lookup response strobe (registered).
- `resp_found_o`  out  1  lookup result; qualified by `resp_valid_o`.
- `tag_err_o`  out  1  sticky: `found_valid_i` arrived with no matching tag.

## Operation
- **Round-robin arbitration.** A register `last_q` holds the last granted index (reset value `NUM_REQ-1`). The grant is the first i with `req_valid_i[i]=1`, searching `last_q+1 … last_q+NUM_REQ` modulo `NUM_REQ`. `last_q` updates only on a grant.
- **Grant enable.** `req_ready_o` is all-zero while `gap_cnt_q != 0`, otherwise the one-hot grant. At most one grant per cycle. Ready does not depend on `req_valid_i` of the granted port beyond the search itself.
- **Insert gap counter.**
  - An insert grant loads `gap_cnt_q = INSERT_GAP`.
  - Otherwise the counter decrements while nonzero.
  - Lookup grants do not load it.
  - `INSERT_GAP = 0` disables blocking.
- **Issue register.** On a grant, `insert_val_o` / `look_up_val_o` (exactly one set) and `ip_addr_o` are loaded. With no grant, both valids go to 0 and `ip_addr_o` holds its value.
- **Tag pipeline.** `LOOKUP_LAT` stages of {`tag_valid`, `tag`}. Stage 0 loads {`look_up_val_o`, issued index} each cycle alongside the issue outputs; the final stage is aligned with `found_valid_i`. Inserts enter as `tag_valid = 0`.
- **Response.**
  - When `found_valid_i` and the final tag is valid: set `resp_valid_o[tag]` and `resp_found_o = found_i` next cycle.
  - When `found_valid_i` and the final tag is not valid: no response, and `tag_err_o` is set, cleared only by reset.
  - A valid final tag without `found_valid_i` is dropped silently and also sets `tag_err_o`.
- **Backpressure.** Responses cannot be backpressured; requesters must accept them.

## Timing
- Grant in cycle t → controller inputs valid in t+1 → `found_valid_i` in t+1+`LOOKUP_LAT` → `resp_valid_o` in t+2+`LOOKUP_LAT` (4 cycles for defaults).
- Throughput:
  - 1 lookup per cycle sustained.
  - An insert is followed by `INSERT_GAP` idle grant cycles; back-to-back inserts are spaced `INSERT_GAP+1` cycles apart.
- **Reset values.** All outputs 0. `last_q = NUM_REQ-1`, `gap_cnt_q = 0`, all tag stages invalid, `ip_addr_o = 0`.
- **Reset mid-operation.** In-flight lookups are discarded and no response is emitted for them. Requesters must reissue.
- **Simultaneous events.**
  - A grant and a response in the same cycle are independent.
  - All requesters valid → strict rotation 0,1,2,3,0…
  - A requester dropping valid before ready is legal and it is simply skipped.
- **Wrap-around.** The round-robin pointer wraps from `NUM_REQ-1` to 0.
- **Gap expiry.** The gap counter reaching 0 re-enables the grant in that same cycle.

## Test plan
- **Reset check.** Assert `rst` asynchronously mid-cycle → all outputs 0 immediately, and the first grant after release goes to requester 0 when all are valid.
- **Round-robin rotation.** All 4 requesters issue continuous lookups → grants 0,1,2,3,0,1. Each `resp_valid_o` arrives 4 cycles after its grant, with the one-hot index matching.
- **Insert then lookup.** Requester 1 inserts 0xC0A80001 at cycle t; requester 2 lookup is pending.
  - No grant at t+1 or t+2; requester 2 is granted at t+3.
  - Its response is `resp_valid_o = 4'b0100` with `resp_found_o = 1` at t+7.
- **Lookup miss.** Lookup of 0x0A000001 (never inserted) → `resp_found_o = 0`, `tag_err_o` stays 0.
- **Reset with lookups in flight.** Reset while 2 lookups are in flight → no `resp_valid_o` after release, and `tag_err_o = 0`.
- **Orphan result.** Force `found_valid_i = 1` with no lookup issued → `tag_err_o = 1` next cycle and it stays set until reset; no `resp_valid_o`.

Source files
------------

// File: rtl/ip_hash_arbiter_if.sv
// Bundle between the requesters, the arbiter and the shared ip_hash_controller.
// The arbiter uses the slave view; the requester/controller environment uses the master view.
interface ip_hash_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int IP_ADDR_W = 32
);
  logic [NUM_REQ-1:0]           req_valid_i;
  logic [NUM_REQ-1:0]           req_insert_i;
  logic [NUM_REQ*IP_ADDR_W-1:0] req_ip_addr_i;
  logic [NUM_REQ-1:0]           req_ready_o;
  logic                         insert_val_o;
  logic                         look_up_val_o;
  logic [IP_ADDR_W-1:0]         ip_addr_o;
  logic                         found_valid_i;
  logic                         found_i;
  logic [NUM_REQ-1:0]           resp_valid_o;
  logic                         resp_found_o;
  logic                         tag_err_o;

  modport slave (
    input  req_valid_i, req_insert_i, req_ip_addr_i, found_valid_i, found_i,
    output req_ready_o, insert_val_o, look_up_val_o, ip_addr_o,
           resp_valid_o, resp_found_o, tag_err_o
  );

  modport master (
    output req_valid_i, req_insert_i, req_ip_addr_i, found_valid_i, found_i,
    input  req_ready_o, insert_val_o, look_up_val_o, ip_addr_o,
           resp_valid_o, resp_found_o, tag_err_o
  );
endinterface

// File: rtl/ip_hash_arbiter.sv
// Round-robin arbiter sharing one ip_hash_controller among NUM_REQ requesters,
// with insert hazard spacing and tag-based routing of lookup results.
module ip_hash_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int IP_ADDR_W  = 32,
  parameter int LOOKUP_LAT = 2,
  parameter int INSERT_GAP = 2
) (
  input  logic               clk,
  input  logic               rst,
  ip_hash_arbiter_if.slave   bus
);
  localparam int TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GAP_W = (INSERT_GAP > 0) ? $clog2(INSERT_GAP + 1) : 1;
  localparam int LAST  = LOOKUP_LAT - 1;

  logic [TAG_W-1:0]     last_q;
  logic [GAP_W-1:0]     gap_cnt_q;
  logic [TAG_W:0]       pick;
  logic                 grant_hit;
  logic [TAG_W-1:0]     grant_idx;
  logic                 grant;
  logic                 grant_insert;
  logic [IP_ADDR_W-1:0] grant_addr;
  logic [TAG_W-1:0]     issue_idx_p0;
  logic                 tag_vld_p [LOOKUP_LAT];
  logic [TAG_W-1:0]     tag_idx_p [LOOKUP_LAT];

  // First valid requester after 'last', scanning downward so the nearest one wins.
  function automatic logic [TAG_W:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                             input logic [TAG_W-1:0]   last);
    logic [TAG_W:0]   res;
    logic [TAG_W-1:0] cidx;
    int               cand;
    res = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = (int'(last) + k) % NUM_REQ;
      cidx = TAG_W'(cand);
      if (vld[cidx]) res = {1'b1, cidx};
    end
    return res;
  endfunction

  always_comb begin
    pick         = rr_pick(bus.req_valid_i, last_q);
    grant_hit    = pick[TAG_W];
    grant_idx    = pick[TAG_W-1:0];
    grant        = grant_hit && (gap_cnt_q == '0) && !rst;
    grant_insert = 1'b0;
    grant_addr   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == TAG_W'(i)) begin
        grant_insert = bus.req_insert_i[i];
        grant_addr   = bus.req_ip_addr_i[i*IP_ADDR_W +: IP_ADDR_W];
      end
    end
    bus.req_ready_o = grant ? (NUM_REQ'(1) << grant_idx) : '0;
  end

  // Arbitration state: rotation pointer and insert hazard counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q    <= TAG_W'(NUM_REQ - 1);
      gap_cnt_q <= '0;
    end else begin
      if (grant) last_q <= grant_idx;
      if (grant && grant_insert)  gap_cnt_q <= GAP_W'(INSERT_GAP);
      else if (gap_cnt_q != '0)   gap_cnt_q <= gap_cnt_q - GAP_W'(1);
    end
  end

  // Issue stage p0: controller inputs, valid one cycle after the grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.insert_val_o  <= 1'b0;
      bus.look_up_val_o <= 1'b0;
      bus.ip_addr_o     <= '0;
    end else begin
      bus.insert_val_o  <= grant & grant_insert;
      bus.look_up_val_o <= grant & ~grant_insert;
      if (grant) bus.ip_addr_o <= grant_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (grant) issue_idx_p0 <= grant_idx;
  end

  // Tag stages p1..: follow the controller pipeline so the last one lines up with found_valid_i.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < LOOKUP_LAT; s++) tag_vld_p[s] <= 1'b0;
    end else begin
      tag_vld_p[0] <= bus.look_up_val_o;
      for (int s = 1; s < LOOKUP_LAT; s++) tag_vld_p[s] <= tag_vld_p[s-1];
    end
  end

  always_ff @(posedge clk) begin
    tag_idx_p[0] <= issue_idx_p0;
    for (int s = 1; s < LOOKUP_LAT; s++) tag_idx_p[s] <= tag_idx_p[s-1];
  end

  // Response stage: route the result to the tagged requester; any misalignment is sticky.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.resp_valid_o <= '0;
      bus.resp_found_o <= 1'b0;
      bus.tag_err_o    <= 1'b0;
    end else begin
      if (bus.found_valid_i && tag_vld_p[LAST]) begin
        bus.resp_valid_o <= NUM_REQ'(1) << tag_idx_p[LAST];
        bus.resp_found_o <= bus.found_i;
      end else begin
        bus.resp_valid_o <= '0;
        bus.resp_found_o <= 1'b0;
      end
      if (bus.found_valid_i != tag_vld_p[LAST]) bus.tag_err_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ip_hash_arbiter.sv
// Randomized and directed bench for ip_hash_arbiter against a cycle-level reference
// model, with a small behavioural ip_hash_controller closing the loop.
module tb_ip_hash_arbiter;
  localparam int N   = 4;
  localparam int AW  = 32;
  localparam int LAT = 2;
  localparam int GAP = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ip_hash_arbiter_if #(.NUM_REQ(N), .IP_ADDR_W(AW)) bus ();

  ip_hash_arbiter #(.NUM_REQ(N), .IP_ADDR_W(AW), .LOOKUP_LAT(LAT), .INSERT_GAP(GAP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural controller: small address table, results delayed by LAT cycles.
  logic [AW-1:0]  ctl_tab [32];
  int             ctl_cnt;
  logic [LAT-1:0] ctl_vld, ctl_hit;
  logic           force_fv;

  function automatic bit ctl_has(input logic [AW-1:0] a);
    for (int j = 0; j < 32; j++) if (j < ctl_cnt && ctl_tab[j] == a) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ctl_vld <= '0;
      ctl_hit <= '0;
      ctl_cnt <= 0;
    end else begin
      ctl_vld <= {ctl_vld[LAT-2:0], bus.look_up_val_o};
      ctl_hit <= {ctl_hit[LAT-2:0], ctl_has(bus.ip_addr_o)};
      if (bus.insert_val_o && !ctl_has(bus.ip_addr_o) && ctl_cnt < 32) begin
        ctl_tab[ctl_cnt] <= bus.ip_addr_o;
        ctl_cnt          <= ctl_cnt + 1;
      end
    end
  end

  assign bus.found_valid_i = ctl_vld[LAT-1] | force_fv;
  assign bus.found_i       = ctl_hit[LAT-1];

  // Reference model state.
  int             n_chk, n_fail, cyc;
  int             last_m, gap_m;
  bit             err_m;
  logic [AW+1:0]  exp_issue;
  bit             mem_m [logic [AW-1:0]];
  logic [N-1:0]   exp_rv [int];
  bit             exp_rf [int];
  logic [N-1:0]   obs_ready, obs_rv;
  logic           obs_rf, obs_err;

  logic [AW-1:0] pool [8] = '{32'hC0A80001, 32'hC0A80002, 32'h0A0A0A0A, 32'h12345678,
                              32'hDEADBEEF, 32'h7F000001, 32'hAC100001, 32'h08080808};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    last_m    = N - 1;
    gap_m     = 0;
    err_m     = 1'b0;
    exp_issue = '0;
    mem_m.delete();
    exp_rv.delete();
    exp_rf.delete();
  endtask

  function automatic logic [N*AW-1:0] rand_addrs();
    logic [N*AW-1:0] r;
    for (int i = 0; i < N; i++) r[i*AW +: AW] = pool[$urandom_range(0, 7)];
    return r;
  endfunction

  // One cycle: drive at the falling edge, check, advance the model, cross the rising edge.
  task automatic step(input logic [N-1:0] v, input logic [N-1:0] ins,
                      input logic [N*AW-1:0] a, input bit fv);
    logic [N-1:0]  er;
    logic [AW-1:0] ga;
    int            g;
    bit            has;
    bus.req_valid_i   = v;
    bus.req_insert_i  = ins;
    bus.req_ip_addr_i = a;
    force_fv          = fv;
    #1;
    has = 1'b0;
    g   = 0;
    er  = '0;
    if (gap_m == 0) begin
      for (int k = 1; k <= N; k++) begin
        int i;
        i = (last_m + k) % N;
        if (!has && v[i]) begin has = 1'b1; g = i; end
      end
    end
    if (has) er[g] = 1'b1;
    obs_ready = bus.req_ready_o;
    obs_rv    = bus.resp_valid_o;
    obs_rf    = bus.resp_found_o;
    obs_err   = bus.tag_err_o;
    chk("ready", 64'(obs_ready), 64'(er));
    chk("issue", 64'({bus.insert_val_o, bus.look_up_val_o, bus.ip_addr_o}), 64'(exp_issue));
    if (exp_rv.exists(cyc)) begin
      chk("resp_valid", 64'(obs_rv), 64'(exp_rv[cyc]));
      chk("resp_found", 64'(obs_rf), 64'(exp_rf[cyc]));
    end else begin
      chk("resp_idle", 64'(obs_rv), 64'(0));
    end
    chk("tag_err", 64'(obs_err), 64'(err_m));
    if (has) begin
      ga        = a[g*AW +: AW];
      last_m    = g;
      exp_issue = {ins[g], ~ins[g], ga};
      if (ins[g]) begin
        mem_m[ga] = 1'b1;
        gap_m     = GAP;
      end else begin
        exp_rv[cyc + LAT + 2] = N'(1) << g;
        exp_rf[cyc + LAT + 2] = mem_m.exists(ga);
      end
    end else begin
      exp_issue[AW+1:AW] = 2'b00;
      if (gap_m > 0) gap_m--;
    end
    if (fv && !exp_rv.exists(cyc + 1)) err_m = 1'b1;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '0, '0, 1'b0);
  endtask

  // Asynchronous reset asserted mid-cycle with every requester valid.
  task automatic do_reset();
    bus.req_valid_i = '1;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rst_ready", 64'(bus.req_ready_o), 64'(0));
    chk("rst_issue", 64'({bus.insert_val_o, bus.look_up_val_o, bus.ip_addr_o}), 64'(0));
    chk("rst_resp", 64'({bus.resp_valid_o, bus.resp_found_o}), 64'(0));
    chk("rst_err", 64'(bus.tag_err_o), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N*AW-1:0] a;
    logic [31:0]     r1, r2, r3;
    n_chk = 0;
    n_fail = 0;
    cyc = 0;
    force_fv = 1'b0;
    bus.req_valid_i = '0;
    bus.req_insert_i = '0;
    bus.req_ip_addr_i = '0;
    rst = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Rotation with all requesters issuing lookups.
    for (int i = 0; i < 6; i++) begin
      step('1, '0, rand_addrs(), 1'b0);
      chk("rotation", 64'(obs_ready), 64'(N'(1) << (i % N)));
    end
    idle(6);

    // Two lookups in flight, then reset: nothing may come back.
    step(4'b0001, '0, rand_addrs(), 1'b0);
    step(4'b0010, '0, rand_addrs(), 1'b0);
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step('0, '0, '0, 1'b0);
      chk("flush_resp", 64'(obs_rv), 64'(0));
      chk("flush_err", 64'(obs_err), 64'(0));
    end

    // Insert by requester 1, lookup of the same address pending on requester 2.
    a = '0;
    a[1*AW +: AW] = 32'hC0A80001;
    a[2*AW +: AW] = 32'hC0A80001;
    step(4'b0110, 4'b0010, a, 1'b0);
    chk("ins_grant", 64'(obs_ready), 64'(4'b0010));
    step(4'b0100, '0, a, 1'b0);
    chk("gap_t1", 64'(obs_ready), 64'(0));
    step(4'b0100, '0, a, 1'b0);
    chk("gap_t2", 64'(obs_ready), 64'(0));
    step(4'b0100, '0, a, 1'b0);
    chk("gap_t3", 64'(obs_ready), 64'(4'b0100));
    idle(3);
    step('0, '0, '0, 1'b0);
    chk("ins_lookup_rv", 64'(obs_rv), 64'(4'b0100));
    chk("ins_lookup_rf", 64'(obs_rf), 64'(1));

    // Lookup of an address never inserted.
    a = '0;
    a[0 +: AW] = 32'h0A000001;
    step(4'b0001, '0, a, 1'b0);
    idle(3);
    step('0, '0, '0, 1'b0);
    chk("miss_rv", 64'(obs_rv), 64'(4'b0001));
    chk("miss_rf", 64'(obs_rf), 64'(0));
    chk("miss_err", 64'(obs_err), 64'(0));

    // Randomized traffic: random valids, ~1/4 inserts, addresses from a small pool.
    for (int i = 0; i < 400; i++) begin
      r1 = $urandom;
      r2 = $urandom;
      r3 = $urandom;
      step(r1[N-1:0], r2[N-1:0] & r3[N-1:0], rand_addrs(), 1'b0);
    end
    idle(6);

    // Orphan result: controller strobe with nothing in flight.
    step('0, '0, '0, 1'b1);
    step('0, '0, '0, 1'b0);
    chk("orphan_err", 64'(obs_err), 64'(1));
    chk("orphan_resp", 64'(obs_rv), 64'(0));
    idle(3);
    chk("orphan_sticky", 64'(obs_err), 64'(1));
    do_reset();
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
